// File: rtl/lsu_byte_ctrl_if.sv
// Request, memory and response bundle for the load/store control stage.
// Latency: none, wiring only.
// Backpressure: req_ready and resp_ready carry flow control; memory side has none.
interface lsu_byte_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_write_data;
  logic [3:0]            mem_write_mask;
  logic [31:0]           mem_read_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_err;

  // View of the load/store stage itself
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_read_data, resp_ready,
    output req_ready, mem_addr, mem_write_data, mem_write_mask,
    output resp_valid, resp_data, resp_err
  );

  // View of the execute stage plus data memory driving the stage
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_read_data, resp_ready,
    input  req_ready, mem_addr, mem_write_data, mem_write_mask,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_byte_ctrl.sv
// Load/store control ahead of byte-addressed data memory; optional MISALIGN_TRAP_EN flags misaligned half/word.
// Latency: request accepted at edge N, response valid after edge N+1 (3 cycles minimum per request).
// Backpressure: one request in flight; resp_ready low holds RESP indefinitely with req_ready low.
module lsu_byte_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,   // asynchronous, active-low
  lsu_byte_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic                  store_q;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic                  legal;
  logic [3:0]            width_mask;
  logic [31:0]           load_ext;

  // Decode the latched request: legality and the byte mask a store would use
  always_comb begin
    legal      = 1'b0;
    width_mask = 4'b0000;
    case (funct3_q)
      3'b000: begin legal = 1'b1; width_mask = 4'b0001; end
      3'b001: begin legal = 1'b1; width_mask = 4'b0011; end
      3'b010: begin legal = 1'b1; width_mask = 4'b1111; end
      3'b100,
      3'b101: legal = !store_q;   // unsigned variants exist for loads only
      default: legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (funct3_q[1:0] == 2'b01 && addr_q[0])          legal = 1'b0;
    if (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) legal = 1'b0;
`endif
  end

  // Sign/zero extension of the memory's combinational read data
  always_comb begin
    load_ext = bus.mem_read_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{bus.mem_read_data[7]}},  bus.mem_read_data[7:0]};
      3'b001:  load_ext = {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b100:  load_ext = {24'h0, bus.mem_read_data[7:0]};
      3'b101:  load_ext = {16'h0, bus.mem_read_data[15:0]};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  // Next-state logic and handshake/mask outputs; mask only ever opens in ACCESS
  always_comb begin
    state_d            = state_q;
    resp_data_d        = resp_data_q;
    resp_err_d         = resp_err_q;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.mem_write_mask = 4'b0000;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (legal && store_q) bus.mem_write_mask = width_mask;
        resp_err_d  = !legal;
        resp_data_d = (legal && !store_q) ? load_ext : 32'h0;
        state_d     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset kills any in-flight store at once
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Capture the request fields when a request is accepted in IDLE
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      store_q  <= 1'b0;
    end else if (state_q == IDLE && bus.req_valid) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
      store_q  <= bus.req_store;
    end
  end

  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_err       = resp_err_q;

endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// Directed bench for lsu_byte_ctrl with a 64-byte wrapping memory model.
// Latency: checks resp_valid two edges after acceptance.
// Backpressure: exercises a five-cycle resp_ready stall.
module tb_lsu_byte_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  lsu_byte_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  lsu_byte_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // Byte memory: combinational read, masked write on the rising edge
  logic [7:0] mem [0:63];
  logic [5:0] ra;
  assign ra = bus.mem_addr[5:0];
  assign bus.mem_read_data = {mem[6'(ra + 6'd3)], mem[6'(ra + 6'd2)],
                              mem[6'(ra + 6'd1)], mem[ra]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bus.mem_write_mask[k])
        mem[6'(ra + 6'(k))] <= bus.mem_write_data[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge and advance to RESP; returns the ACCESS-cycle mask
  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [3:0] m_obs);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    m_obs = bus.mem_write_mask;
    chk({tag, "_access_valid"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] exp_mask, input logic [31:0] exp_data,
                     input logic exp_err);
    logic [3:0] m;
    issue(tag, st, f3, addr, wd, m);
    chk({tag, "_mask"},      32'(m),                  32'(exp_mask));
    chk({tag, "_valid"},     32'(bus.resp_valid),     32'd1);
    chk({tag, "_data"},      bus.resp_data,           exp_data);
    chk({tag, "_err"},       32'(bus.resp_err),       32'(exp_err));
    chk({tag, "_resp_mask"}, 32'(bus.mem_write_mask), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.req_ready),  32'd1);
  endtask

  initial begin
    logic [3:0] m;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mask",  32'(bus.mem_write_mask), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid),     32'd0);
    chk("rst_data",  bus.resp_data,           32'd0);
    chk("rst_err",   32'(bus.resp_err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // Reference word, then a store aborted by reset during ACCESS
    txn("sw10", 1'b1, 3'b010, 32'h10, 32'h1111_1111, 4'b1111, 32'h0, 1'b0);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_mask_before", 32'(bus.mem_write_mask), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("abort_mask_async", 32'(bus.mem_write_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.req_ready),  32'd1);
    chk("abort_valid", 32'(bus.resp_valid), 32'd0);
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h1111_1111, 1'b0);

    // Word store/load
    txn("sw4", 1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    txn("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);

    // Byte store, signed and unsigned byte loads
    txn("sb8",  1'b1, 3'b000, 32'h8, 32'h0000_00F0, 4'b0001, 32'h0, 1'b0);
    txn("lb8",  1'b0, 3'b000, 32'h8, 32'h0, 4'b0000, 32'hFFFF_FFF0, 1'b0);
    txn("lbu8", 1'b0, 3'b100, 32'h8, 32'h0, 4'b0000, 32'h0000_00F0, 1'b0);

    // Halfword store, signed and unsigned halfword loads
    txn("shc",  1'b1, 3'b001, 32'hC, 32'h1234_8123, 4'b0011, 32'h0, 1'b0);
    txn("lhc",  1'b0, 3'b001, 32'hC, 32'h0, 4'b0000, 32'hFFFF_8123, 1'b0);
    txn("lhuc", 1'b0, 3'b101, 32'hC, 32'h0, 4'b0000, 32'h0000_8123, 1'b0);

    // Back-pressure: five stalled cycles in RESP
    bus.resp_ready = 1'b0;
    issue("bp", 1'b0, 3'b010, 32'h4, 32'h0, m);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.resp_valid),     32'd1);
      chk("bp_data",  bus.resp_data,           32'hDEAD_BEEF);
      chk("bp_ready", 32'(bus.req_ready),      32'd0);
      chk("bp_mask",  32'(bus.mem_write_mask), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.req_ready),  32'd1);

    // Illegal encodings
    txn("ill_ld011", 1'b0, 3'b011, 32'h4,  32'h0,  4'b0000, 32'h0, 1'b1);
    txn("ill_st100", 1'b1, 3'b100, 32'h20, 32'h55, 4'b0000, 32'h0, 1'b1);
    txn("ill_st111", 1'b1, 3'b111, 32'h20, 32'h55, 4'b0000, 32'h0, 1'b1);
    txn("lw4_again", 1'b0, 3'b010, 32'h4,  32'h0,  4'b0000, 32'hDEAD_BEEF, 1'b0);

    // Misaligned halfword load at 0x3
    txn("sb3", 1'b1, 3'b000, 32'h3, 32'h0000_0080, 4'b0001, 32'h0, 1'b0);
    txn("sb4", 1'b1, 3'b000, 32'h4, 32'h0000_0000, 4'b0001, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    txn("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
    txn("lh3", 1'b0, 3'b001, 32'h3, 32'h0, 4'b0000, 32'h0000_0080, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_byte_ctrl.md
Name: lsu_byte_ctrl

Overview:
Load/store control stage directly upstream of the byte-addressable data memory in frisc. Accepts one load or store request from the execute stage over a valid/ready handshake and drives the memory's byte address, write data and 4-bit write mask. For loads, it captures the memory's combinational read data and sign- or zero-extends it. Returns one response per request over a second valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, width of request and memory byte address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
mem_addr  out  ADDR_WIDTH  byte address to memory
mem_write_data  out  32  store data to memory, byte k at bits [8k+7:8k]
mem_write_mask  out  4  per-byte write enable to memory
mem_read_data  in  32  memory read data, byte at mem_addr in [7:0], combinational
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal or misaligned request

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; resp_valid=0; resp_data=0; resp_err=0; mem_write_mask=0; latched addr/data/funct3/store=0. req_ready=1 once in IDLE. A store in flight at reset is aborted: mask drops to 0 immediately, and no write occurs on a later edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at the edge, latch req_* and go to ACCESS.
- ACCESS (exactly 1 cycle): req_ready=0.
  - Loads: capture extended mem_read_data into resp_data at the edge.
  - Legal stores: mem_write_mask is nonzero this cycle only; memory writes at the closing edge.
  - Then go to RESP.
- RESP: resp_valid=1, and resp_data/resp_err are held stable. When resp_ready=1 at the edge, go to IDLE. No new request is accepted in the same cycle.
- Timing: request accepted at edge N → resp_valid high after edge N+1. Minimum 3 cycles per request. resp_ready back-pressure stalls indefinitely.
- mem_addr always equals the latched address.
- mem_write_data = latched wdata, unshifted.
- mem_write_mask is 0 in every state except ACCESS.
- funct3 decode:
  - 000: LB / SB; store mask 0001.
  - 001: LH / SH; store mask 0011.
  - 010: LW / SW; store mask 1111.
  - 100: LBU; load only.
  - 101: LHU; load only.
  - Any other code, or 100/101 with store=1: illegal. resp_err=1, resp_data=0, mask stays 0.
- Load extension:
  - LB sign-extends bits [7:0]; LBU zero-extends.
  - LH sign-extends [15:0]; LHU zero-extends.
  - LW passes all 32 bits.
- Stores return resp_data=0, resp_err=0 when legal.
- Address arithmetic belongs to the memory. The block never modifies the address; wrap-around at the top of the address space is the memory's concern.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword access with addr[0]≠0, or word access with addr[1:0]≠0, is treated as illegal. Result: resp_err=1, resp_data=0, mask 0 (no memory write).
- Undefined: misaligned accesses proceed normally, because the memory handles unaligned byte addresses. resp_err reflects funct3 legality only.

Test Plan:
- Reset: hold reset=0 mid-ACCESS of an SW → mask=0 immediately; after release, state=IDLE, req_ready=1, resp_valid=0, no memory change.
- SW: addr=0x4, wdata=0xDEADBEEF → mask=1111 for one cycle, resp_valid after 2 edges, resp_data=0, resp_err=0. Follow with LW at 0x4 → resp_data=0xDEADBEEF.
- SB then loads: SB wdata=0x000000F0 at 0x8 (mask=0001). LB at 0x8 → resp_data=0xFFFFFFF0; LBU at 0x8 → 0x000000F0.
- Back-pressure: hold resp_ready=0 for 5 cycles → resp_valid stays 1, resp_data stable, req_ready=0, mask=0. Raising resp_ready returns the FSM to IDLE next edge.
- Illegal codes: funct3=011 load, and store with funct3=100 → resp_err=1, resp_data=0, mask never nonzero.
- Misaligned LH at 0x3:
  - With MISALIGN_TRAP_EN: resp_err=1.
  - Without: memory bytes 0x3=0x80, 0x4=0x00 → resp_data=0x00000080, resp_err=0.
